branch_predictor: RTL and testbench

//  Bimodal branch predictor, the consumer end of the execute-stage branch comparator's br_en.

---
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counter table, registered mispredict flag, stats.
// Optional GSHARE_EN: PC index XOR'd with a non-speculative global history register.
module bp_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_upd,
  input  logic       i_taken,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} state_t;
  state_t r_state, w_next;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= WNT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_upd) begin
      case (r_state)
        SNT: w_next = i_taken ? WNT : SNT;
        WNT: w_next = i_taken ? WT  : SNT;
        WT:  w_next = i_taken ? ST  : WNT;
        ST:  w_next = i_taken ? ST  : WT;
        default: w_next = WNT;
      endcase
    end
  end

  always_comb o_state = r_state;
endmodule

module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pred_req,
  input  logic [31:0]         pred_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_br_en,
  input  logic                upd_pred_taken,
  output logic                mispredict,
  input  logic                stat_clr,
  output logic [CNT_W-1:0]    br_count,
  output logic [CNT_W-1:0]    mp_count
);
  localparam int DEPTH = 2**IDX_BITS;

  logic [IDX_BITS-1:0] w_idx;
  logic [1:0]          w_ctr [DEPTH];
  logic                w_mp;
  logic                w_unused_pc;

  logic                r_pred_valid, r_pred_taken, r_mispredict;
  logic [IDX_BITS-1:0] r_pred_idx;
  logic [CNT_W-1:0]    r_br_count, r_mp_count;

  assign w_unused_pc = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

`ifdef GSHARE_EN
  logic [IDX_BITS-1:0] r_ghr;
  // History is trained at execute only; a same-cycle request sees the pre-shift value.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_ghr <= '0;
    else if (upd_valid) r_ghr <= {r_ghr[IDX_BITS-2:0], upd_br_en};
  end
  assign w_idx = pred_pc[IDX_BITS+1:2] ^ r_ghr;
`else
  assign w_idx = pred_pc[IDX_BITS+1:2];
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    bp_ctr u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_upd   (upd_valid && (upd_idx == IDX_BITS'(g))),
      .i_taken (upd_br_en),
      .o_state (w_ctr[g])
    );
  end

  assign w_mp = upd_valid && (upd_br_en != upd_pred_taken);

  // Table read uses the registered (pre-update) counter: no same-cycle bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
      r_mispredict <= 1'b0;
    end else begin
      r_pred_valid <= pred_req;
      r_mispredict <= w_mp;
      if (pred_req) begin
        r_pred_taken <= w_ctr[w_idx][1];
        r_pred_idx   <= w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else begin
      if (upd_valid && (r_br_count != '1)) r_br_count <= r_br_count + CNT_W'(1);
      if (w_mp && (r_mp_count != '1))      r_mp_count <= r_mp_count + CNT_W'(1);
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred_idx   = r_pred_idx;
  assign mispredict = r_mispredict;
  assign br_count   = r_br_count;
  assign mp_count   = r_mp_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: reference table model, predictions queued at request
// and popped on pred_valid. Honours GSHARE_EN when defined.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n, pred_req, upd_valid, upd_br_en, upd_pred_taken, stat_clr;
  logic [31:0] pred_pc;
  logic [5:0]  upd_idx;
  logic        pred_valid, pred_taken, mispredict;
  logic [5:0]  pred_idx;
  logic [31:0] br_count, mp_count;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_br_en(upd_br_en),
    .upd_pred_taken(upd_pred_taken), .mispredict(mispredict), .stat_clr(stat_clr),
    .br_count(br_count), .mp_count(mp_count)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [1:0]  m_tbl [64];
  logic [5:0]  m_ghr;
  logic        m_last_taken, m_exp_valid, m_exp_mp;
  logic [5:0]  m_last_idx;
  logic [31:0] m_br, m_mp;
  logic [6:0]  sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
    m_ghr = '0; m_last_taken = 1'b0; m_last_idx = '0;
    m_br = '0; m_mp = '0; m_exp_valid = 1'b0; m_exp_mp = 1'b0;
    sb_q.delete();
  endtask

  task automatic cyc(input logic rst, input logic req, input logic [31:0] pc,
                     input logic uv, input logic [5:0] uidx, input logic br,
                     input logic pt, input logic clr);
    logic [5:0] idx;
    logic [6:0] e;
    rst_n = rst; pred_req = req; pred_pc = pc; upd_valid = uv; upd_idx = uidx;
    upd_br_en = br; upd_pred_taken = pt; stat_clr = clr;
    if (!rst) model_reset();
    else begin
      m_exp_valid = req;
      if (req) begin
`ifdef GSHARE_EN
        idx = pc[7:2] ^ m_ghr;
`else
        idx = pc[7:2];
`endif
        sb_q.push_back({m_tbl[idx][1], idx});
        m_last_taken = m_tbl[idx][1];
        m_last_idx   = idx;
      end
      m_exp_mp = uv && (br != pt);
      if (uv) begin
        if (br && m_tbl[uidx] != 2'b11) m_tbl[uidx] = m_tbl[uidx] + 2'b01;
        if (!br && m_tbl[uidx] != 2'b00) m_tbl[uidx] = m_tbl[uidx] - 2'b01;
        m_ghr = {m_ghr[4:0], br};
      end
      if (clr) begin
        m_br = '0; m_mp = '0;
      end else begin
        if (uv && m_br != '1) m_br = m_br + 1;
        if (m_exp_mp && m_mp != '1) m_mp = m_mp + 1;
      end
    end
    @(posedge clk); #1;
    chk("pred_valid", {31'b0, pred_valid}, {31'b0, m_exp_valid});
    if (pred_valid) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, e[6]});
        chk("pred_idx", {26'b0, pred_idx}, {26'b0, e[5:0]});
      end
    end else begin
      chk("hold_taken", {31'b0, pred_taken}, {31'b0, m_last_taken});
      chk("hold_idx", {26'b0, pred_idx}, {26'b0, m_last_idx});
    end
    chk("mispredict", {31'b0, mispredict}, {31'b0, m_exp_mp});
    chk("br_count", br_count, m_br);
    chk("mp_count", mp_count, m_mp);
  endtask

  task automatic pred(input logic [31:0] pc);
    cyc(1, 1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [5:0] uidx, input logic br, input logic pt);
    cyc(1, 0, 0, 1, uidx, br, pt, 0);
  endtask

  initial begin
    model_reset();
    cyc(0, 1, 32'h40, 1, 6'h10, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, pred_valid}, 32'd0);
    // 1: cold predict
    pred(32'h0000_0040);
    chk("t1_idx", {26'b0, pred_idx}, 32'h10);
    // 2: train to strongly taken, then saturate
    upd(6'h10, 1, 0);
    upd(6'h10, 1, 0);
    pred(32'h40);
    chk("t2_taken", {31'b0, pred_taken}, 32'd1);
    for (int i = 0; i < 4; i++) upd(6'h10, 1, 1);
    pred(32'h40);
    // 3: two not-taken from strongly taken
    upd(6'h10, 0, 1);
    pred(32'h40);
    chk("t3_wt", {31'b0, pred_taken}, 32'd1);
    upd(6'h10, 0, 1);
    pred(32'h40);
    chk("t3_wnt", {31'b0, pred_taken}, 32'd0);
    // 4: mispredict pulse and statistics clear
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    upd(6'h20, 1, 0);
    chk("t4_mp", {31'b0, mispredict}, 32'd1);
    chk("t4_br", br_count, 32'd1);
    chk("t4_mpc", mp_count, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_pulse", {31'b0, mispredict}, 32'd0);
    cyc(1, 0, 0, 1, 6'h21, 1, 0, 1);
    chk("t4_clr_br", br_count, 32'd0);
    // 5: same-cycle predict and update, then fresh request
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h40, 1, 6'h10, 1, 1, 0);
    chk("t5_old", {31'b0, pred_taken}, 32'd0);
    pred(32'h40);
    chk("t5_new", {31'b0, pred_taken}, 32'd1);
    // random mixed traffic
    for (int i = 0; i < 300; i++)
      cyc(1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 31) == 0));
    // 6: mid-stream reset with a request in flight, then sweep every entry
    cyc(1, 1, 32'h44, 1, 6'h11, 1, 0, 0);
    cyc(0, 1, 32'h48, 1, 6'h12, 1, 0, 0);
    chk("t6_valid", {31'b0, pred_valid}, 32'd0);
    for (int i = 0; i < 64; i++) pred(32'(i) << 2);
    upd(6'h01, 1, 1);
    upd(6'h02, 0, 0);
    pred(32'h40);
`ifdef GSHARE_EN
    chk("t6_gshare_idx", {26'b0, pred_idx}, 32'h12);
`else
    chk("t6_bimodal_idx", {26'b0, pred_idx}, 32'h10);
`endif
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
